// File: rtl/byte_fifo_if.sv
// Producer/consumer handshake bundle for byte_fifo: push side, pop side and status.
// The FIFO uses the slave modport; the surrounding logic uses master.
interface byte_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic                         in_valid;
   logic                         in_ready;
   logic [WIDTH-1:0]             din;
   logic                         out_valid;
   logic                         out_ready;
   logic [WIDTH-1:0]             dout;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         almost_full;
   logic                         overflow;

   modport slave (
      input  in_valid, din, out_ready,
      output in_ready, out_valid, dout, count, almost_full, overflow
   );

   modport master (
      output in_valid, din, out_ready,
      input  in_ready, out_valid, dout, count, almost_full, overflow
   );
endinterface

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO feeding the downstream register's d input.
// Push-to-pop latency 1 cycle; in_ready drops only when full (no bypass), pops are consumer-paced.
module byte_fifo #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = 3
) (
   input  logic      clk,
   input  logic      rst,
   byte_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             ovf;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Flags derive from registered occupancy only, so no input reaches them combinationally.
   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);
   assign push  = bus.in_valid && !full;
   assign pop   = bus.out_ready && !empty;

   // Storage is deliberately left out of reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= bus.din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + CW'(1);
         end else if (pop && !push) begin
            cnt <= cnt - CW'(1);
         end
         if (bus.in_valid && full) begin
            ovf <= 1'b1;
         end
      end
   end

   assign bus.in_ready    = !full;
   assign bus.out_valid   = !empty;
   assign bus.dout        = mem[rd_ptr];
   assign bus.count       = cnt;
   assign bus.almost_full = (cnt >= CW'(AF_LEVEL));
   assign bus.overflow    = ovf;
endmodule

// File: tb/tb_byte_fifo.sv
// Scoreboard bench for byte_fifo: directed scenarios followed by random push/pop/reset traffic.
module tb_byte_fifo;
   localparam int DEPTH = 4;
   localparam int AF    = 3;

   logic clk;
   logic rst;
   byte_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bif ();

   byte_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] sb[$];
   bit         m_ovf;
   bit         chk_en;
   int         total;
   int         bad;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Monitor: status against model occupancy, head byte against the queue front, pop on handshake.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count", 32'(bif.count), 32'(sb.size()));
         chk("in_ready", 32'(bif.in_ready), 32'(sb.size() != DEPTH));
         chk("out_valid", 32'(bif.out_valid), 32'(sb.size() != 0));
         chk("almost_full", 32'(bif.almost_full), 32'(sb.size() >= AF));
         chk("overflow", 32'(bif.overflow), 32'(m_ovf));
         if (sb.size() > 0) begin
            chk("dout", 32'(bif.dout), 32'(sb[0]));
            if (bif.out_ready) begin
               void'(sb.pop_front());
            end
         end
      end
   end

   // One clock of stimulus; the model consequence is applied just after the edge it belongs to.
   task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit rs);
      bit acc;
      bit ovf;
      bif.in_valid  = v;
      bif.din       = d;
      bif.out_ready = r;
      rst           = rs;
      acc = v && !rs && (sb.size() < DEPTH);
      ovf = v && !rs && (sb.size() >= DEPTH);
      @(posedge clk);
      #1;
      if (rs) begin
         sb.delete();
         m_ovf = 1'b0;
      end else begin
         if (acc) sb.push_back(d);
         if (ovf) m_ovf = 1'b1;
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      chk_en = 1'b0;
      m_ovf = 1'b0;
      bif.in_valid = 1'b0;
      bif.din = '0;
      bif.out_ready = 1'b0;
      rst = 1'b1;

      cyc(0, 8'h00, 0, 1);
      chk_en = 1'b1;
      cyc(0, 8'h00, 0, 1);
      repeat (2) cyc(0, 8'h00, 0, 0);

      // Fill, overflow attempt, drain.
      cyc(1, 8'h11, 0, 0);
      cyc(1, 8'h22, 0, 0);
      cyc(1, 8'h33, 0, 0);
      cyc(1, 8'h44, 0, 0);
      cyc(1, 8'h55, 0, 0);
      cyc(0, 8'h00, 0, 0);
      repeat (5) cyc(0, 8'h00, 1, 0);

      // Simultaneous push/pop at count 2.
      cyc(1, 8'hA0, 0, 0);
      cyc(1, 8'hA1, 0, 0);
      cyc(1, 8'hA2, 1, 0);
      repeat (3) cyc(0, 8'h00, 1, 0);

      // Streaming with occupancy held at one across pointer wrap.
      cyc(1, 8'h00, 0, 0);
      for (int i = 1; i < 16; i++) cyc(1, 8'(i), 1, 0);
      repeat (2) cyc(0, 8'h00, 1, 0);

      // Reset mid-burst, then a fresh push.
      cyc(1, 8'h61, 0, 0);
      cyc(1, 8'h62, 0, 0);
      cyc(1, 8'h63, 0, 0);
      cyc(1, 8'h99, 1, 1);
      cyc(1, 8'h7E, 0, 0);
      repeat (2) cyc(0, 8'h00, 1, 0);

      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : 1) & 1'($urandom_range(0, 1) | (i[8] ? 1 : 0)),
             $urandom_range(0, 99) == 0);
      end
      repeat (6) cyc(0, 8'h00, 1, 0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/byte_fifo.md
# byte_fifo

Synchronous first-word-fall-through byte FIFO that sits directly upstream of the 8-bit `register` stage. It buffers bursty byte traffic from a ready/valid producer and presents the head entry on `dout`, which drives the register's `d` input. Pops are ready/valid, so the consumer controls when each byte leaves the FIFO. Everything runs on one clock.

## Interface
- `WIDTH`, 8, data width in bits; matches the downstream `d[7:0]`.
- `DEPTH`, 4, number of entries; must be a power of two and at least 2.
- `AF_LEVEL`, 3, occupancy at or above which `almost_full` asserts; valid range 1..DEPTH.

- `clk`  input  1  the single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  producer has a byte on `din`.
- `in_ready`  output  1  FIFO can accept a byte this cycle.
- `din`  input  WIDTH  write data.
- `out_valid`  output  1  `dout` holds a valid head entry.
- `out_ready`  input  1  consumer takes the head entry this cycle.
- `dout`  output  WIDTH  head entry; connects to the register's `d[7:0]`.
- `count`  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- `almost_full`  output  1  high when `count >= AF_LEVEL`.
- `overflow`  output  1  sticky; set by a write attempt while full.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. This is combinational from registered state and never depends on `out_ready`.
  - A full FIFO therefore refuses a push even in a cycle that also pops; there is no bypass.
- `out_valid = (count != 0)`.
- `dout = mem[rd_ptr]`, read combinationally from the storage array (first-word-fall-through).
  - When `out_valid` is 0, `dout` is unspecified and must not be checked.
- Pointers `wr_ptr` and `rd_ptr` are log2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- Occupancy update:
  - Push only: `count + 1`.
  - Pop only: `count - 1`.
  - Push and pop together: `count` unchanged, both pointers advance.
  - Neither: `count` unchanged.
- Simultaneous push and pop while empty cannot occur, because `out_valid` is 0.
- Simultaneous push and pop with `0 < count < DEPTH` is legal. The popped byte is the old head; the pushed byte goes to the tail.
- `overflow` is set on any cycle with `in_valid && !in_ready` while not in reset. It is cleared only by `rst`. `din` is dropped in that cycle.
- A pop request while empty is ignored; there is no underflow flag.
- Reset (`rst` high at the clock edge):
  - `wr_ptr`, `rd_ptr` and `count` go to 0, and `overflow` goes to 0.
  - Storage contents are not cleared.
  - Push and pop in the reset cycle are ignored.
- Reset mid-burst discards all buffered bytes. After reset the outputs are: `out_valid`=0, `in_ready`=1, `count`=0, `almost_full`=0, `overflow`=0.

## Timing
- Write-to-read latency is 1 cycle.
  - A byte pushed at edge N appears on `dout` with `out_valid`=1 immediately after edge N, so it is poppable in cycle N+1.
- `in_ready`, `out_valid`, `count` and `almost_full` change only after a clock edge; there are no combinational paths from inputs to these outputs.
- Throughput is one push and one pop per cycle in steady state with `0 < count < DEPTH`.
- When full, in_ready re-asserts in the cycle after the first pop.
- `overflow` asserts in the cycle after the offending attempt.

## Test plan
- Reset, then idle -> `out_valid`=0, `in_ready`=1, `count`=0, `overflow`=0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready`=0 -> `count` steps 1, 2, 3, 4.
  - `almost_full` rises when `count` reaches 3.
  - `in_ready`=0 after the fourth push.
  - `dout` stays 0x11 throughout.
- With the FIFO full, assert `in_valid` with `din`=0x55 -> `overflow`=1 on the next cycle and `count` stays 4.
  - Then drain with `out_ready`=1 -> `dout` sequence is 0x11, 0x22, 0x33, 0x44 and 0x55 never appears.
- With `count`=2 (holding 0xA0, 0xA1), push 0xA2 and pop in the same cycle -> `count` stays 2, next `dout`=0xA1, then 0xA2.
- Continuous push and pop of 0x00..0x0F with `count` held at 1 -> output order matches input across pointer wrap-around, with no gaps.
- Push 3 bytes, assert `rst` for one cycle alongside `in_valid`=1 and `out_ready`=1 -> the next cycle shows `count`=0, `out_valid`=0, `in_ready`=1.
  - The next push of 0x7E appears on `dout` one cycle later.
